// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over a
// req/ready handshake, holds it for the control unit and flags memory timeouts.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           PC_STEP     = 4,
  parameter int unsigned           HOLD_CYCLES = 2,
  parameter int unsigned           TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_increment,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_error
);

  localparam int unsigned HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int unsigned WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [31:0]           instr_nxt;
  logic                  valid_nxt;
  logic                  req_nxt;
  logic                  err_nxt;
  logic [HW-1:0]         hold_cnt, hold_nxt;
  logic [WW-1:0]         wait_cnt, wait_nxt;
  logic                  hold_done_c;
  logic                  timeout_hit_c;

  // The current HOLD cycle counts toward the minimum, so compare the incremented count.
  assign hold_done_c   = (32'(hold_cnt) + 32'd1) >= HOLD_CYCLES;
  assign timeout_hit_c = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) >= TIMEOUT);
  assign imem_addr     = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_error <= 1'b0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      instr_valid <= valid_nxt;
      imem_req    <= req_nxt;
      fetch_error <= err_nxt;
      hold_cnt    <= hold_nxt;
      wait_cnt    <= wait_nxt;
    end
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instruction;
    valid_nxt = instr_valid;
    req_nxt   = imem_req;
    err_nxt   = fetch_error;
    hold_nxt  = hold_cnt;
    wait_nxt  = wait_cnt;
    case (state)
      ST_FETCH: begin
        req_nxt = 1'b1;
        if (imem_req && imem_ready) begin
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
          hold_nxt  = '0;
          state_nxt = ST_HOLD;
        end else if (imem_req) begin
          if (timeout_hit_c) begin
            req_nxt   = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = ST_ERROR;
          end else begin
            wait_nxt = wait_cnt + WW'(1);
          end
        end
      end
      ST_HOLD: begin
        valid_nxt = 1'b1;
        if (hold_cnt != HW'(HOLD_CYCLES)) begin
          hold_nxt = hold_cnt + HW'(1);
        end
        // Stall wins over a simultaneous advance request.
        if (hold_done_c && pc_increment && !stall) begin
          pc_nxt    = pc + ADDR_WIDTH'(PC_STEP);
          valid_nxt = 1'b0;
          wait_nxt  = '0;
          req_nxt   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_ERROR: begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b1;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a cycle-level reference model
// derived from the fetch / hold / timeout rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC     = 32'hFFFF_FFF8;
  localparam int          STEP    = 4;
  localparam int          HOLD    = 2;
  localparam int          TMO     = 16;

  logic        clk;
  logic        reset;
  logic        pc_increment;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic        fetch_error;

  instr_fetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (RPC),
    .PC_STEP    (STEP),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_increment(pc_increment),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .fetch_error (fetch_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the control unit should see, plus how long the
  // current word has been shown and how long the memory has kept us waiting.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_req;
  bit          m_err;
  int          m_age;
  int          m_waited;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = RPC;
    m_instr  = '0;
    m_valid  = 1'b0;
    m_req    = 1'b0;
    m_err    = 1'b0;
    m_age    = 0;
    m_waited = 0;
  endtask

  task automatic model_step(input bit r, input bit inc, input bit stl, input bit rdy,
                            input logic [31:0] data);
    if (r) begin
      model_reset();
    end else if (m_err) begin
      m_req = 1'b0;
    end else if (!m_valid) begin
      if (!m_req) begin
        m_req = 1'b1;
      end else if (rdy) begin
        m_instr = data;
        m_valid = 1'b1;
        m_req   = 1'b0;
        m_age   = 0;
      end else begin
        m_waited++;
        if (m_waited >= TMO) begin
          m_err = 1'b1;
          m_req = 1'b0;
        end
      end
    end else begin
      m_age++;
      if (m_age >= HOLD && inc && !stl) begin
        m_pc     = m_pc + 32'(STEP);
        m_valid  = 1'b0;
        m_req    = 1'b1;
        m_waited = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", 32'(imem_req), 32'(m_req));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instruction", instruction, m_instr);
    check("fetch_error", 32'(fetch_error), 32'(m_err));
  endtask

  // Check outputs mid-cycle, then drive one cycle of inputs and advance the model.
  task automatic step(input bit r, input bit inc, input bit stl, input bit rdy,
                      input logic [31:0] data);
    @(negedge clk);
    compare_all();
    reset        = r;
    pc_increment = inc;
    stall        = stl;
    imem_ready   = rdy;
    imem_rdata   = data;
    @(posedge clk);
    model_step(r, inc, stl, rdy, data);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    pc_increment = 1'b0;
    stall        = 1'b0;
    imem_ready   = 1'b0;
    imem_rdata   = '0;
    @(posedge clk);
    @(posedge clk);
    model_reset();

    // Ready tied high, advance always requested: back-to-back fetches and PC wrap.
    for (int k = 0; k < 24; k++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom);

    // Slow memory: five cycles of ready low before the capture.
    for (int k = 0; k < 10 && m_valid; k++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h2001_0005);

    // Stall held across the hold window with pc_increment high.
    for (int k = 0; k < 10 && !m_valid; k++) step(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
           ($urandom % 3) == 0, $urandom);
    end

    // Memory that never answers: timeout, sticky error, ready ignored afterwards.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom);

    // Reset in the middle of a pending fetch, then a clean restart.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom);

    @(negedge clk);
    compare_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
